// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Brief    : Two-entry FIFO skid buffer between the ALU and writeback, plus
//            the architectural NZVC flag register and the B.LT condition.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
  parameter int DEPTH = 2  // skid entries; the 1-bit pointers only support 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] result,
  input  logic        negative,
  input  logic        zero,
  input  logic        overflow,
  input  logic        carry_out,
  input  logic        set_flags,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_c,
  output logic        cond_lt,
  output logic [1:0]  count
);

  // Entry storage
  logic [63:0]      r_mem_result [DEPTH];
  logic [4:0]       r_mem_rd     [DEPTH];
  logic [DEPTH-1:0] r_mem_we;

  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  logic r_flag_n;
  logic r_flag_z;
  logic r_flag_v;
  logic r_flag_c;

  logic w_accept;
  logic w_drain;
  logic w_flag_load;

  // Handshake decode; in_ready depends on registered occupancy only, so there
  // is no combinational path from out_ready back to the ALU.
  assign in_ready    = (r_count != 2'd2);
  assign out_valid   = (r_count != 2'd0);
  assign w_accept    = in_valid & in_ready & ~flush;
  assign w_drain     = out_valid & out_ready;
  assign w_flag_load = w_accept & set_flags;

  assign out_result    = r_mem_result[r_rd_ptr];
  assign out_rd        = r_mem_rd[r_rd_ptr];
  assign out_reg_write = r_mem_we[r_rd_ptr];
  assign count         = r_count;

  assign flag_n  = r_flag_n;
  assign flag_z  = r_flag_z;
  assign flag_v  = r_flag_v;
  assign flag_c  = r_flag_c;
  assign cond_lt = r_flag_n ^ r_flag_v;

  // Write accepted entries into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_result[i] <= '0;
        r_mem_rd[i]     <= '0;
      end
      r_mem_we <= '0;
    end else if (w_accept) begin
      r_mem_result[r_wr_ptr] <= result;
      r_mem_rd[r_wr_ptr]     <= rd;
      r_mem_we[r_wr_ptr]     <= reg_write;
    end
  end

  // Pointer and occupancy tracking; flush empties the buffer and rewinds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_accept) r_wr_ptr <= ~r_wr_ptr;
      if (w_drain)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_accept} - {1'b0, w_drain};
    end
  end

  // Architectural flags load only on a real, non-flushed accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_v <= 1'b0;
      r_flag_c <= 1'b0;
    end else if (w_flag_load) begin
      r_flag_n <= negative;
      r_flag_z <= zero;
      r_flag_v <= overflow;
      r_flag_c <= carry_out;
    end
  end

endmodule
`default_nettype wire
